unified_cache_miss_queue: RTL and testbench
===========================================

# unified_cache_miss_queue

In-order FIFO that buffers miss packets between the unified cache bank's miss request output and the memory-side interface, decoupling bank stalls from memory backpressure. Provides registered about-to-full back-pressure, which the bank uses to raise miss-replay priority. Preserves per-packet critical flags.

## Interface
- `SINGLE_ENTRY_SIZE_IN_BITS`, default `` `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS ``: packet width; packet contents are opaque to this block.
- `QUEUE_SIZE`, default 8: number of entries; power of two, ≥2.
- `ALMOST_FULL_THRESHOLD`, default `QUEUE_SIZE - 2`: occupancy at or above which `is_about_to_full_out` is asserted; range 1..`QUEUE_SIZE`.

Ports:
- `clk_in` in 1: single clock, rising edge.
- `reset_in` in 1: asynchronous, active-high reset.
- `request_in` in `SINGLE_ENTRY_SIZE_IN_BITS`: miss packet from the bank.
- `request_valid_in` in 1: `request_in` is valid.
- `request_critical_in` in 1: critical flag for `request_in`.
- `issue_ack_out` out 1: packet accepted this cycle.
- `request_out` out `SINGLE_ENTRY_SIZE_IN_BITS`: head packet.
- `request_valid_out` out 1: head is valid.
- `request_critical_out` out 1: head critical flag OR `is_about_to_full_out`.
- `issue_ack_in` in 1: downstream consumed the head this cycle.
- `is_about_to_full_out` out 1: occupancy ≥ `ALMOST_FULL_THRESHOLD`.
- `occupancy_out` out `$clog2(QUEUE_SIZE)+1`: current entry count.

## Operation
- Storage: `QUEUE_SIZE` × (packet + critical bit) register array; write pointer and read pointer each `$clog2(QUEUE_SIZE)` bits, wrapping naturally modulo `QUEUE_SIZE`; occupancy counter `$clog2(QUEUE_SIZE)+1` bits.
- Status: full = (occupancy == `QUEUE_SIZE`); empty = (occupancy == 0). Both are derived from the registered counter only.
- Enqueue: `enq = request_valid_in & ~full`. `issue_ack_out = enq`, combinational from registered state and `request_valid_in`. On enqueue, write packet and critical bit at the write pointer, then increment the write pointer.
- Dequeue: `deq = request_valid_out & issue_ack_in`. On dequeue, increment the read pointer. `issue_ack_in` while empty is ignored; no pointer or counter change.
- Occupancy update, next cycle:
  - +1 on enq only.
  - −1 on deq only.
  - unchanged on both or neither.
- Full case: no enqueue while full, even if a dequeue happens in the same cycle. There is no pass-through.
- Empty case: no bypass; a packet enqueued into an empty queue appears at the output the next cycle.
- Output:
  - `request_valid_out = ~empty`.
  - `request_out` and the head critical bit are read from the array at the read pointer.
  - When empty, `request_out` is don't-care and is driven to 0.
- Order: strict FIFO; critical flags do not reorder entries.
- `is_about_to_full_out` and `occupancy_out` are driven from the registered counter.

## Timing
- Reset (asynchronous assert, clears on the next edge after deassert):
  - Pointers and occupancy go to 0.
  - `request_valid_out`=0, `request_out`=0, `request_critical_out`=0, `is_about_to_full_out`=0, `occupancy_out`=0.
  - `issue_ack_out`=0 while reset is high.
  - Array contents need not be cleared.
- Reset mid-operation: all queued packets are discarded; no partial packet is emitted.
- Latency: enqueue at edge N → `request_valid_out`=1 from cycle N+1.
- Throughput: one enqueue and one dequeue per cycle sustained when neither full nor empty.
- Handshake rules:
  - Upstream may drop valid at any time.
  - The head (`request_out`, `request_critical_out`) stays stable until `issue_ack_in` is sampled high with valid.
- `is_about_to_full_out` changes one cycle after the occupancy transition that crosses the threshold.

## Test plan
Bench configuration: `QUEUE_SIZE`=4, `ALMOST_FULL_THRESHOLD`=3.
- Reset: assert `reset_in` asynchronously mid-cycle with 2 entries queued → all outputs 0 immediately. After release, `occupancy_out`=0 and `request_valid_out`=0.
- Ordering: enqueue A1..A4 with `issue_ack_in`=0.
  - `issue_ack_out`=1 for four cycles, 0 on a fifth attempt.
  - `occupancy_out`=4.
  - `is_about_to_full_out`=1 from the cycle after the third enqueue.
  - Drain → A1, A2, A3, A4 in order.
- Full plus simultaneous dequeue: with the queue full, `request_valid_in`=1 and `issue_ack_in`=1 → `issue_ack_out`=0; occupancy becomes 3; enqueue is accepted the following cycle.
- Concurrent streaming: at occupancy 2, enq and deq every cycle for 10 cycles → occupancy stays 2 and pointers wrap at least twice with correct packet order.
- Critical flag:
  - Enqueue B (critical=1) then C (critical=0) at occupancy 0 → `request_critical_out`=1 for B, 0 for C.
  - Fill to 3 entries → `request_critical_out`=1 regardless of the head's flag.
- Empty ack: `issue_ack_in`=1 while empty for 3 cycles, then enqueue D → `occupancy_out`=1 and D is presented at the output.

Source files
------------

// File: rtl/unified_cache_miss_queue.sv
// unified_cache_miss_queue
// In-order FIFO buffering miss packets between the unified cache bank and the
// memory-side interface. Each entry carries an opaque packet plus a critical
// flag. Almost-full status is registered and also forces the outgoing
// critical flag so the bank can raise miss-replay priority.
//
// Ports:
//   clk_in, reset_in         : clock (rising edge), async active-high reset
//   request_in/_valid_in     : packet from the bank
//   request_critical_in      : critical flag of request_in
//   issue_ack_out            : packet accepted this cycle
//   request_out/_valid_out   : head packet towards memory
//   request_critical_out     : head critical flag OR almost-full
//   issue_ack_in             : downstream consumed the head
//   is_about_to_full_out     : occupancy >= ALMOST_FULL_THRESHOLD
//   occupancy_out            : current entry count

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 64
`endif

module unified_cache_miss_queue #(
  parameter int unsigned SINGLE_ENTRY_SIZE_IN_BITS = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
  parameter int unsigned QUEUE_SIZE                = 8,
  parameter int unsigned ALMOST_FULL_THRESHOLD     = QUEUE_SIZE - 2
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_in,
  input  logic                                 request_valid_in,
  input  logic                                 request_critical_in,
  output logic                                 issue_ack_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_out,
  output logic                                 request_valid_out,
  output logic                                 request_critical_out,
  input  logic                                 issue_ack_in,
  output logic                                 is_about_to_full_out,
  output logic [$clog2(QUEUE_SIZE):0]          occupancy_out
);

  localparam int unsigned PTR_W = $clog2(QUEUE_SIZE);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] data_q [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0]                crit_q;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             about_full_q, about_full_d;

  logic full_c, empty_c, enq_c, deq_c;

  // Status from the registered counter only; reset gates the accept.
  assign full_c  = (occ_q == CNT_W'(QUEUE_SIZE));
  assign empty_c = (occ_q == '0);
  assign enq_c   = request_valid_in & ~full_c & ~reset_in;
  assign deq_c   = ~empty_c & issue_ack_in;

  // Next-state for pointers, occupancy and almost-full.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (enq_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq_c, deq_c})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
    about_full_d = (occ_d >= CNT_W'(ALMOST_FULL_THRESHOLD));
  end

  // Control state register.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      about_full_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      about_full_q <= about_full_d;
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk_in) begin
    if (enq_c) begin
      data_q[wr_ptr_q] <= request_in;
      crit_q[wr_ptr_q] <= request_critical_in;
    end
  end

  // Head is zeroed when empty so reset/empty present all-zero outputs.
  assign issue_ack_out        = enq_c;
  assign request_valid_out    = ~empty_c;
  assign request_out          = empty_c ? '0 : data_q[rd_ptr_q];
  assign request_critical_out = (~empty_c & crit_q[rd_ptr_q]) | about_full_q;
  assign is_about_to_full_out = about_full_q;
  assign occupancy_out        = occ_q;

endmodule

// File: tb/tb_unified_cache_miss_queue.sv
// Testbench for unified_cache_miss_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_unified_cache_miss_queue;

  localparam int unsigned W      = 16;
  localparam int unsigned QS     = 4;
  localparam int unsigned THRESH = 3;

  logic          clk_in;
  logic          reset_in;
  logic [W-1:0]  request_in;
  logic          request_valid_in;
  logic          request_critical_in;
  logic          issue_ack_out;
  logic [W-1:0]  request_out;
  logic          request_valid_out;
  logic          request_critical_out;
  logic          issue_ack_in;
  logic          is_about_to_full_out;
  logic [2:0]    occupancy_out;

  unified_cache_miss_queue #(
    .SINGLE_ENTRY_SIZE_IN_BITS(W),
    .QUEUE_SIZE(QS),
    .ALMOST_FULL_THRESHOLD(THRESH)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .request_in(request_in),
    .request_valid_in(request_valid_in),
    .request_critical_in(request_critical_in),
    .issue_ack_out(issue_ack_out),
    .request_out(request_out),
    .request_valid_out(request_valid_out),
    .request_critical_out(request_critical_out),
    .issue_ack_in(issue_ack_in),
    .is_about_to_full_out(is_about_to_full_out),
    .occupancy_out(occupancy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [W-1:0] data;
    logic         crit;
  } pkt_t;

  pkt_t model_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare outputs with the model mid-cycle,
  // then apply the model's queue semantics at the rising edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic c, input logic ack);
    int  sz;
    bit  exp_enq, exp_deq, exp_about;
    request_valid_in    = v;
    request_in          = d;
    request_critical_in = c;
    issue_ack_in        = ack;
    #3;
    sz        = model_q.size();
    exp_enq   = v && (sz < QS);
    exp_deq   = ack && (sz > 0);
    exp_about = (sz >= THRESH);
    check("occupancy", 32'(occupancy_out), 32'(sz));
    check("valid_out", 32'(request_valid_out), 32'(sz > 0));
    check("ack_out", 32'(issue_ack_out), 32'(exp_enq));
    check("about_full", 32'(is_about_to_full_out), 32'(exp_about));
    check("data_out", 32'(request_out), (sz > 0) ? 32'(model_q[0].data) : 32'd0);
    check("crit_out", 32'(request_critical_out),
          32'(((sz > 0) && model_q[0].crit) || exp_about));
    @(posedge clk_in);
    if (exp_deq) void'(model_q.pop_front());
    if (exp_enq) model_q.push_back('{data: d, crit: c});
    #1;
  endtask

  initial begin
    reset_in            = 1'b1;
    request_in          = '0;
    request_valid_in    = 1'b0;
    request_critical_in = 1'b0;
    issue_ack_in        = 1'b0;
    #2;
    check("rst_valid", 32'(request_valid_out), 32'd0);
    check("rst_occ", 32'(occupancy_out), 32'd0);
    check("rst_ack_out", 32'(issue_ack_out), 32'd0);
    repeat (2) @(posedge clk_in);
    #1 reset_in = 1'b0;

    // Async reset with two entries queued.
    step(1, 16'hAA01, 1, 0);
    step(1, 16'hAA02, 0, 0);
    #2;
    request_valid_in = 1'b1;
    reset_in         = 1'b1;
    #1;
    check("mid_rst_valid", 32'(request_valid_out), 32'd0);
    check("mid_rst_data", 32'(request_out), 32'd0);
    check("mid_rst_crit", 32'(request_critical_out), 32'd0);
    check("mid_rst_about", 32'(is_about_to_full_out), 32'd0);
    check("mid_rst_occ", 32'(occupancy_out), 32'd0);
    check("mid_rst_ack", 32'(issue_ack_out), 32'd0);
    @(posedge clk_in);
    #1 reset_in = 1'b0;
    model_q.delete();
    step(0, '0, 0, 0);

    // Fill A1..A4, fifth attempt refused, then drain in order.
    for (int i = 1; i <= 5; i++) step(1, 16'hA000 + 16'(i), 0, 0);
    check("full_occ", 32'(occupancy_out), 32'd4);
    for (int i = 0; i < 4; i++) step(0, '0, 0, 1);

    // Full with simultaneous dequeue: no pass-through, enqueue next cycle.
    for (int i = 1; i <= 4; i++) step(1, 16'hB000 + 16'(i), 0, 0);
    step(1, 16'hBEEF, 0, 1);
    check("full_deq_occ", 32'(occupancy_out), 32'd3);
    step(1, 16'hBEF0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 0, 1);

    // Concurrent streaming at occupancy 2.
    step(1, 16'hC000, 0, 0);
    step(1, 16'hC001, 1, 0);
    for (int i = 2; i < 12; i++) step(1, 16'hC000 + 16'(i), 1'(i % 3 == 0), 1);
    check("stream_occ", 32'(occupancy_out), 32'd2);
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);

    // Critical flag per entry, then forced by almost-full.
    step(1, 16'hB00B, 1, 0);
    step(1, 16'hC00C, 0, 0);
    step(0, '0, 0, 1);
    step(1, 16'hD001, 0, 0);
    step(1, 16'hD002, 0, 0);
    step(0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1);

    // Acks while empty are ignored.
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1);
    step(1, 16'hD00D, 0, 0);
    check("empty_ack_occ", 32'(occupancy_out), 32'd1);
    check("empty_ack_data", 32'(request_out), 32'hD00D);
    step(0, '0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 60), 16'($urandom), 1'($urandom),
           1'($urandom_range(0, 99) < 50));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
